// File: rtl/score_pkg.sv
// Shared definitions for the score readout: seven-segment glyphs (active-low
// gfedcba), the converter FSM state type and a constant power-of-ten helper
// used to size the saturation limit.
package score_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, // 0
    7'b1111001, // 1
    7'b0100100, // 2
    7'b0110000, // 3
    7'b0011001, // 4
    7'b0010010, // 5
    7'b0000010, // 6
    7'b1111000, // 7
    7'b0000000, // 8
    7'b0010000  // 9
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Non-decimal nibbles cannot occur in a finished conversion; show them blank.
  function automatic logic [6:0] seg_lookup(input logic [3:0] d);
    if (d < 4'd10) return SEG_DIGIT[d];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/score_display_if.sv
// Signal bundle between the game-logic side (master) and the score readout
// (slave).
//   score     : live binary score
//   gameover  : game-over level
//   show_high : 1 displays the high-score register instead of the live score
//   hex       : hex[i] is decimal digit i (0 = units), active-low gfedcba
//   busy      : a conversion is in progress
//   overflow  : the displayed value was saturated
//   fsm_state : converter state, for observation only
interface score_display_if #(
  parameter int W      = 10,
  parameter int DIGITS = 3
);
  import score_pkg::*;

  logic [W-1:0]           score;
  logic                   gameover;
  logic                   show_high;
  logic [DIGITS-1:0][6:0] hex;
  logic                   busy;
  logic                   overflow;
  conv_state_e            fsm_state;

  modport master (
    output score, gameover, show_high,
    input  hex, busy, overflow, fsm_state
  );

  modport slave (
    input  score, gameover, show_high,
    output hex, busy, overflow, fsm_state
  );

endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
//   clk, reset : clock, synchronous active-high reset (aborts a conversion)
//   start      : begin converting value (accepted only in IDLE)
//   value      : binary input, must already fit in DIGITS decimal digits
//   busy       : high in SHIFT and DONE
//   done       : high for the single DONE cycle, when bcd holds the result
//   bcd        : BCD result, nibble i = decimal digit i
//   state_dbg  : current FSM state
//
// Handshake: start is a request qualified by !busy. It is taken on the edge
// where start=1 and busy=0; while busy=1 start is ignored, so nothing queues.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int W      = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [W-1:0]          value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output conv_state_e           state_dbg
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);

  conv_state_e       state_q, state_d;
  logic [BW+W-1:0]   sr_q, sr_d;   // {bcd digits, remaining binary}
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     adj;

  // Add-3 correction for every BCD nibble >= 5, applied before the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sr_q[W+4*i +: 4] >= 4'd5) adj[4*i +: 4] = sr_q[W+4*i +: 4] + 4'd3;
      else                          adj[4*i +: 4] = sr_q[W+4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BW{1'b0}}, value};
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Binary MSB moves into the BCD LSB.
        sr_d  = {adj, sr_q[W-1:0]} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign bcd       = sr_q[BW+W-1:W];
  assign state_dbg = state_q;

endmodule

// File: rtl/score_display.sv
// Score readout: converts the live or high score to DIGITS active-low
// seven-segment digits, saturating at 10^DIGITS-1, keeps a high score
// captured on each game-over rise, and blinks the display during game over.
//   clk, reset : clock, synchronous active-high reset
//   bus        : score_display_if slave (score, gameover, show_high in;
//                hex, busy, overflow, fsm_state out)
// W is expected to be at most 31 bits.
module score_display
  import score_pkg::*;
#(
  parameter int W            = 10,
  parameter int DIGITS       = 3,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int LZ_BLANK     = 0
) (
  input  logic             clk,
  input  logic             reset,
  score_display_if.slave   bus
);

  localparam int unsigned MAXV   = pow10(DIGITS) - 1;
  localparam logic [31:0] MAXV32 = 32'(MAXV);
  localparam int          BCW    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [W-1:0]          src, conv_value, last_src_q, high_score_q;
  logic [31:0]           src_ext;
  logic                  src_ovf, start, conv_busy, conv_done;
  logic [4*DIGITS-1:0]   bcd, digits_q;
  logic                  ovf_pend_q, overflow_q;
  logic                  gameover_q, gameover_rise;
  logic [BCW-1:0]        blink_cnt_q;
  logic                  phase_q;      // 1 = blanked half-period
  conv_state_e           conv_state;
  logic [DIGITS-1:0][6:0] seg;
  logic [DIGITS-1:0]     blank;
  logic                  lead;

  assign src        = bus.show_high ? high_score_q : bus.score;
  assign src_ext    = 32'(src);
  // When MAXV >= 2^W-1 this compare is never true, so overflow stays 0.
  assign src_ovf    = (src_ext > MAXV32);
  assign conv_value = src_ovf ? W'(MAXV32) : src;
  // Only an IDLE converter looks at src, so the latest value always wins.
  assign start      = !conv_busy && (src != last_src_q);

  bin2bcd_seq #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .value     (conv_value),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd       (bcd),
    .state_dbg (conv_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      last_src_q <= '0;
      ovf_pend_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start) begin
        last_src_q <= src;
        ovf_pend_q <= src_ovf;
      end
      if (conv_done) begin
        digits_q   <= bcd;
        overflow_q <= ovf_pend_q;
      end
    end
  end

  assign gameover_rise = bus.gameover && !gameover_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gameover_q   <= 1'b0;
      high_score_q <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
    end else begin
      gameover_q <= bus.gameover;
      // High score is stored unsaturated; clamping happens at display time.
      if (gameover_rise && (bus.score > high_score_q)) high_score_q <= bus.score;
      if (!bus.gameover || gameover_rise) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (blink_cnt_q == BCW'(BLINK_CYCLES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Walk from the most significant digit down; a digit is a leading zero
  // while it and everything above it are zero. Digit 0 always shows.
  always_comb begin
    seg   = '0;
    blank = '0;
    lead  = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lead     = lead && (digits_q[4*i +: 4] == 4'd0);
      blank[i] = lead && (i != 0) && (LZ_BLANK != 0);
      seg[i]   = seg_lookup(digits_q[4*i +: 4]);
    end
  end

  always_comb begin
    bus.hex = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bus.hex[i] = (phase_q || blank[i]) ? SEG_BLANK : seg[i];
    end
  end

  assign bus.busy      = conv_busy;
  assign bus.overflow  = overflow_q;
  assign bus.fsm_state = conv_state;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;
  import score_pkg::*;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'h7F;

  // ---------------- clock / reset / stimulus signals ----------------
  logic       clk;
  logic       reset;
  logic [9:0] score;
  logic       gameover;
  logic       show_high;

  int n_checks;
  int n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  score_display_if #(.W(10), .DIGITS(3)) bus0 ();
  score_display_if #(.W(10), .DIGITS(3)) bus1 ();

  assign bus0.score     = score;
  assign bus0.gameover  = gameover;
  assign bus0.show_high = show_high;
  assign bus1.score     = score;
  assign bus1.gameover  = gameover;
  assign bus1.show_high = show_high;

  score_display #(.W(10), .DIGITS(3), .BLINK_CYCLES(4), .LZ_BLANK(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  score_display #(.W(10), .DIGITS(3), .BLINK_CYCLES(4), .LZ_BLANK(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  // Advance n rising edges; land 2 time units after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- driver / check tasks ----------------
  task automatic test_reset();
    reset = 1'b1; score = '0; gameover = 1'b0; show_high = 1'b0;
    tick(2);
    n_checks++;
    if (bus0.hex !== {S0, S0, S0}) $display("FAIL reset_hex: got %h expected %h", bus0.hex, {S0, S0, S0});
    else n_pass++;
    n_checks++;
    if (bus1.hex !== {BL, BL, S0}) $display("FAIL reset_hex_lz: got %h expected %h", bus1.hex, {BL, BL, S0});
    else n_pass++;
    n_checks++;
    if (bus0.busy !== 1'b0 || bus0.overflow !== 1'b0)
      $display("FAIL reset_flags: got busy=%b ovf=%b expected 0 0", bus0.busy, bus0.overflow);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_convert_25();
    int busy_cnt;
    busy_cnt = 0;
    score = 10'd25;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      if (bus0.busy === 1'b1) busy_cnt++;
      if (c == 11) begin
        n_checks++;
        if (bus0.hex !== {S0, S0, S0}) $display("FAIL conv25_early: got %h expected %h", bus0.hex, {S0, S0, S0});
        else n_pass++;
      end
    end
    n_checks++;
    if (bus0.hex !== {S0, S2, S5}) $display("FAIL conv25_hex: got %h expected %h", bus0.hex, {S0, S2, S5});
    else n_pass++;
    n_checks++;
    if (bus1.hex !== {BL, S2, S5}) $display("FAIL conv25_hex_lz: got %h expected %h", bus1.hex, {BL, S2, S5});
    else n_pass++;
    n_checks++;
    if (busy_cnt != 11) $display("FAIL conv25_busy_cycles: got %0d expected 11", busy_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate();
    score = 10'd999;
    tick(13);
    n_checks++;
    if (bus0.hex !== {S9, S9, S9} || bus0.overflow !== 1'b0)
      $display("FAIL sat_999: got %h ovf=%b expected %h ovf=0", bus0.hex, bus0.overflow, {S9, S9, S9});
    else n_pass++;
    score = 10'd1000;
    tick(13);
    n_checks++;
    if (bus0.hex !== {S9, S9, S9} || bus0.overflow !== 1'b1)
      $display("FAIL sat_1000: got %h ovf=%b expected %h ovf=1", bus0.hex, bus0.overflow, {S9, S9, S9});
    else n_pass++;
    score = 10'd1023;
    tick(13);
    n_checks++;
    if (bus0.hex !== {S9, S9, S9} || bus0.overflow !== 1'b1)
      $display("FAIL sat_1023: got %h ovf=%b expected %h ovf=1", bus0.hex, bus0.overflow, {S9, S9, S9});
    else n_pass++;
    score = 10'd0;
    tick(13);
    n_checks++;
    if (bus0.hex !== {S0, S0, S0} || bus0.overflow !== 1'b0)
      $display("FAIL sat_back_0: got %h ovf=%b expected %h ovf=0", bus0.hex, bus0.overflow, {S0, S0, S0});
    else n_pass++;
    n_checks++;
    if (bus1.hex !== {BL, BL, S0}) $display("FAIL sat_back_0_lz: got %h expected %h", bus1.hex, {BL, BL, S0});
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    score = 10'd61;
    tick(3);            // third SHIFT cycle of the 61 conversion
    score = 10'd576;
    tick(9);            // 12 edges since 61 was applied: DONE wrote 61
    n_checks++;
    if (bus0.hex !== {S0, S6, S1}) $display("FAIL b2b_first: got %h expected %h", bus0.hex, {S0, S6, S1});
    else n_pass++;
    n_checks++;
    if (bus0.busy !== 1'b0) $display("FAIL b2b_idle_after_done: got busy=%b expected 0", bus0.busy);
    else n_pass++;
    tick(11);
    n_checks++;
    if (bus0.hex !== {S0, S6, S1}) $display("FAIL b2b_hold: got %h expected %h", bus0.hex, {S0, S6, S1});
    else n_pass++;
    tick(1);
    n_checks++;
    if (bus0.hex !== {S5, S7, S6}) $display("FAIL b2b_second: got %h expected %h", bus0.hex, {S5, S7, S6});
    else n_pass++;
  endtask

  task automatic test_high_score();
    score = 10'd320; gameover = 1'b1;   // rise and score change on the same edge
    tick(1);
    gameover = 1'b0; score = 10'd100;
    tick(1);
    gameover = 1'b1;                    // lower score at second rise
    tick(1);
    gameover = 1'b0;
    tick(30);
    n_checks++;
    if (bus0.hex !== {S1, S0, S0}) $display("FAIL hs_live_100: got %h expected %h", bus0.hex, {S1, S0, S0});
    else n_pass++;
    show_high = 1'b1;
    tick(30);
    n_checks++;
    if (bus0.hex !== {S3, S2, S0}) $display("FAIL hs_keep_320: got %h expected %h", bus0.hex, {S3, S2, S0});
    else n_pass++;
    score = 10'd750; gameover = 1'b1;
    tick(1);
    gameover = 1'b0; score = 10'd40;
    tick(30);
    n_checks++;
    if (bus0.hex !== {S7, S5, S0}) $display("FAIL hs_raise_750: got %h expected %h", bus0.hex, {S7, S5, S0});
    else n_pass++;
    show_high = 1'b0;
    tick(30);
    n_checks++;
    if (bus0.hex !== {S0, S4, S0}) $display("FAIL hs_back_live_40: got %h expected %h", bus0.hex, {S0, S4, S0});
    else n_pass++;
  endtask

  task automatic test_blink();
    logic [20:0] exp_hex;
    score = 10'd7;
    tick(13);
    n_checks++;
    if (bus1.hex !== {BL, BL, S7}) $display("FAIL lz_7: got %h expected %h", bus1.hex, {BL, BL, S7});
    else n_pass++;
    gameover = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      // Visible for 4 cycles from the rise, blanked for the next 4, repeating.
      exp_hex = (c >= 4 && c < 8) ? {BL, BL, BL} : {S0, S0, S7};
      n_checks++;
      if (bus0.hex !== exp_hex) $display("FAIL blink_c%0d: got %h expected %h", c, bus0.hex, exp_hex);
      else n_pass++;
    end
    gameover = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      n_checks++;
      if (bus0.hex !== {S0, S0, S7}) $display("FAIL blink_steady_c%0d: got %h expected %h", c, bus0.hex, {S0, S0, S7});
      else n_pass++;
    end
  endtask

  task automatic test_lz_blank();
    score = 10'd0;
    tick(13);
    n_checks++;
    if (bus1.hex !== {BL, BL, S0}) $display("FAIL lz_0: got %h expected %h", bus1.hex, {BL, BL, S0});
    else n_pass++;
    score = 10'd105;
    tick(13);
    n_checks++;
    if (bus1.hex !== {S1, S0, S5}) $display("FAIL lz_inner_zero: got %h expected %h", bus1.hex, {S1, S0, S5});
    else n_pass++;
    score = 10'd40;
    tick(13);
    n_checks++;
    if (bus1.hex !== {BL, S4, S0}) $display("FAIL lz_40: got %h expected %h", bus1.hex, {BL, S4, S0});
    else n_pass++;
  endtask

  task automatic test_reset_mid_shift();
    score = 10'd1023;
    tick(13);
    n_checks++;
    if (bus0.overflow !== 1'b1) $display("FAIL rst_pre_ovf: got %b expected 1", bus0.overflow);
    else n_pass++;
    score = 10'd123;
    tick(3);
    n_checks++;
    if (bus0.busy !== 1'b1 || bus0.fsm_state !== SHIFT)
      $display("FAIL rst_pre_shift: got busy=%b state=%0d expected 1 %0d", bus0.busy, bus0.fsm_state, SHIFT);
    else n_pass++;
    reset = 1'b1;
    tick(1);
    n_checks++;
    if (bus0.hex !== {S0, S0, S0} || bus1.hex !== {BL, BL, S0})
      $display("FAIL rst_mid_hex: got %h/%h expected %h/%h", bus0.hex, bus1.hex, {S0, S0, S0}, {BL, BL, S0});
    else n_pass++;
    n_checks++;
    if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0 || bus0.overflow !== 1'b0)
      $display("FAIL rst_mid_flags: got busy=%b/%b ovf=%b expected 0/0 0", bus0.busy, bus1.busy, bus0.overflow);
    else n_pass++;
    reset = 1'b0;
    tick(13);
    n_checks++;
    if (bus0.hex !== {S1, S2, S3}) $display("FAIL rst_then_123: got %h expected %h", bus0.hex, {S1, S2, S3});
    else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1; score = '0; gameover = 1'b0; show_high = 1'b0;
    test_reset();
    test_convert_25();
    test_saturate();
    test_back_to_back();
    test_high_score();
    test_blink();
    test_lz_blank();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
